// File: rtl/histogram_prefix_scanner.sv
// Two-pass histogram scanner: totals pass, then a cumulative (count, intensity) stream.
// Optional macro HIST_SCAN_CLEAR_EN adds a write port that zeroes each bin as it is scanned.
module histogram_prefix_scanner #(
   parameter int unsigned BIN_BITS        = 8,
   parameter int unsigned COUNT_WIDTH     = 32,
   parameter int unsigned INTENSITY_WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   output logic                       busy,
   output logic                       done,
   output logic                       hist_rd_en,
   output logic [BIN_BITS-1:0]        hist_rd_addr,
   input  logic [COUNT_WIDTH-1:0]     hist_rd_data,
   output logic [COUNT_WIDTH-1:0]     total_pixels,
   output logic [INTENSITY_WIDTH-1:0] total_intensity_sum,
   output logic                       totals_valid,
   output logic [COUNT_WIDTH-1:0]     cumulative_count,
   output logic [INTENSITY_WIDTH-1:0] cumulative_sum,
   output logic                       out_valid,
   output logic                       out_last,
   input  logic                       out_ready
`ifdef HIST_SCAN_CLEAR_EN
   ,
   output logic                       hist_wr_en,
   output logic [BIN_BITS-1:0]        hist_wr_addr,
   output logic [COUNT_WIDTH-1:0]     hist_wr_data
`endif
);

   localparam int unsigned NUM_BINS = 2 ** BIN_BITS;
   localparam int unsigned PTR_W    = BIN_BITS + 1;
   localparam int unsigned PROD_W   = COUNT_WIDTH + BIN_BITS;
   localparam logic [BIN_BITS-1:0] LAST_BIN = BIN_BITS'(NUM_BINS - 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_TOTAL    = 3'd1,
      S_ANNOUNCE = 3'd2,
      S_SCAN     = 3'd3,
      S_DONE     = 3'd4
   } state_t;

   state_t state, state_nxt;

   logic [PTR_W-1:0]           rd_ptr;
   logic                       rd_vld;
   logic [BIN_BITS-1:0]        rd_idx;
   logic [COUNT_WIDTH-1:0]     acc_cnt;
   logic [INTENSITY_WIDTH-1:0] acc_sum;
   logic [COUNT_WIDTH-1:0]     e1_cnt;
   logic [INTENSITY_WIDTH-1:0] e1_sum;
   logic                       e1_last;
   logic                       e1_vld;

   logic                       rd_issue_c;
   logic                       reads_left_c;
   logic                       credit_ok_c;
   logic                       pop_c;
   logic                       push_c;
   logic                       push_last_c;
   logic [PROD_W-1:0]          prod_c;
   logic [INTENSITY_WIDTH-1:0] contrib_c;
   logic [COUNT_WIDTH-1:0]     acc_cnt_nxt_c;
   logic [INTENSITY_WIDTH-1:0] acc_sum_nxt_c;

   assign hist_rd_addr  = rd_ptr[BIN_BITS-1:0];
   assign reads_left_c  = !rd_ptr[PTR_W-1];
   assign pop_c         = out_valid && out_ready;
   assign push_c        = (state == S_SCAN) && rd_vld;
   assign push_last_c   = (rd_idx == LAST_BIN);
   // Slots held after this cycle (FIFO + returning data - pop) must leave room for a new read.
   assign credit_ok_c   = (3'(out_valid) + 3'(e1_vld) + 3'(rd_vld)) < (3'd2 + 3'(pop_c));
   assign prod_c        = PROD_W'(hist_rd_data) * PROD_W'(rd_idx);
   assign contrib_c     = INTENSITY_WIDTH'(prod_c);
   assign acc_cnt_nxt_c = acc_cnt + hist_rd_data;
   assign acc_sum_nxt_c = acc_sum + contrib_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:     if (start) state_nxt = S_TOTAL;
         S_TOTAL:    if (rd_vld && (rd_idx == LAST_BIN)) state_nxt = S_ANNOUNCE;
         S_ANNOUNCE: state_nxt = S_SCAN;
         S_SCAN:     if (pop_c && out_last) state_nxt = S_DONE;
         S_DONE:     state_nxt = S_IDLE;
         default:    state_nxt = S_IDLE;
      endcase
   end

   // Read strobe depends on the current pop so the 2-entry FIFO sustains one beat per cycle.
   always_comb begin
      rd_issue_c = 1'b0;
      case (state)
         S_TOTAL: rd_issue_c = reads_left_c;
         S_SCAN:  rd_issue_c = reads_left_c && credit_ok_c;
         default: rd_issue_c = 1'b0;
      endcase
   end

   assign hist_rd_en = rd_issue_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy                <= 1'b0;
         done                <= 1'b0;
         totals_valid        <= 1'b0;
         rd_ptr              <= '0;
         rd_vld              <= 1'b0;
         rd_idx              <= '0;
         total_pixels        <= '0;
         total_intensity_sum <= '0;
         acc_cnt             <= '0;
         acc_sum             <= '0;
         cumulative_count    <= '0;
         cumulative_sum      <= '0;
         out_last            <= 1'b0;
         out_valid           <= 1'b0;
         e1_cnt              <= '0;
         e1_sum              <= '0;
         e1_last             <= 1'b0;
         e1_vld              <= 1'b0;
      end else begin
         busy         <= (state_nxt != S_IDLE);
         done         <= (state_nxt == S_DONE);
         totals_valid <= (state_nxt == S_ANNOUNCE);
         rd_vld       <= rd_issue_c;
         rd_idx       <= hist_rd_addr;
         if (rd_issue_c) rd_ptr <= rd_ptr + PTR_W'(1);

         case (state)
            S_IDLE: if (start) begin
               rd_ptr              <= '0;
               total_pixels        <= '0;
               total_intensity_sum <= '0;
               acc_cnt             <= '0;
               acc_sum             <= '0;
            end
            S_TOTAL: begin
               if (rd_vld) begin
                  total_pixels        <= total_pixels + hist_rd_data;
                  total_intensity_sum <= total_intensity_sum + contrib_c;
               end
               if (state_nxt == S_ANNOUNCE) rd_ptr <= '0;
            end
            S_SCAN: if (rd_vld) begin
               acc_cnt <= acc_cnt_nxt_c;
               acc_sum <= acc_sum_nxt_c;
            end
            default: ;
         endcase

         // Output FIFO: head drives the stream ports, e1 is the second slot.
         if (pop_c) begin
            if (e1_vld) begin
               cumulative_count <= e1_cnt;
               cumulative_sum   <= e1_sum;
               out_last         <= e1_last;
               if (push_c) begin
                  e1_cnt  <= acc_cnt_nxt_c;
                  e1_sum  <= acc_sum_nxt_c;
                  e1_last <= push_last_c;
               end else begin
                  e1_vld <= 1'b0;
               end
            end else if (push_c) begin
               cumulative_count <= acc_cnt_nxt_c;
               cumulative_sum   <= acc_sum_nxt_c;
               out_last         <= push_last_c;
            end else begin
               out_valid <= 1'b0;
            end
         end else if (push_c) begin
            if (!out_valid) begin
               cumulative_count <= acc_cnt_nxt_c;
               cumulative_sum   <= acc_sum_nxt_c;
               out_last         <= push_last_c;
               out_valid        <= 1'b1;
            end else begin
               e1_cnt  <= acc_cnt_nxt_c;
               e1_sum  <= acc_sum_nxt_c;
               e1_last <= push_last_c;
               e1_vld  <= 1'b1;
            end
         end
      end
   end

`ifdef HIST_SCAN_CLEAR_EN
   // Zero each bin in the cycle its scan data returns; the RAM is then reading the next bin.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_wr_en   <= 1'b0;
         hist_wr_addr <= '0;
      end else begin
         hist_wr_en   <= rd_issue_c && (state == S_SCAN);
         hist_wr_addr <= hist_rd_addr;
      end
   end

   assign hist_wr_data = '0;
`endif

endmodule

// File: tb/tb_histogram_prefix_scanner.sv
// Directed bench for histogram_prefix_scanner: scoreboard of expected beats and totals.
module tb_histogram_prefix_scanner;

   localparam int unsigned BB = 2;
   localparam int unsigned NB = 4;
   localparam int unsigned CW = 32;
   localparam int unsigned IW = 32;
   localparam int unsigned NW = 4;

   typedef struct packed {
      logic [CW-1:0] cnt;
      logic [IW-1:0] sum;
      logic          last;
   } beat_t;

   typedef struct packed {
      logic [NW-1:0] cnt;
      logic [NW-1:0] sum;
      logic          last;
   } beat_b_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n, start, out_ready;
   logic          busy, done, rd_en, totals_valid, out_valid, out_last;
   logic [BB-1:0] rd_addr;
   logic [CW-1:0] rd_data, total_pixels, cum_cnt;
   logic [IW-1:0] total_isum, cum_sum;

   logic          start_b, ready_b;
   logic          busy_b, done_b, rd_en_b, tv_b, valid_b, last_b;
   logic [BB-1:0] rd_addr_b;
   logic [NW-1:0] rd_data_b, tp_b, ts_b, cc_b, cs_b;

`ifdef HIST_SCAN_CLEAR_EN
   logic          wr_en, wr_en_b;
   logic [BB-1:0] wr_addr, wr_addr_b;
   logic [CW-1:0] wr_data;
   logic [NW-1:0] wr_data_b;
   int            wr_log[$];
`endif

   histogram_prefix_scanner #(.BIN_BITS(BB), .COUNT_WIDTH(CW), .INTENSITY_WIDTH(IW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .hist_rd_en(rd_en), .hist_rd_addr(rd_addr), .hist_rd_data(rd_data),
      .total_pixels(total_pixels), .total_intensity_sum(total_isum), .totals_valid(totals_valid),
      .cumulative_count(cum_cnt), .cumulative_sum(cum_sum),
      .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready)
`ifdef HIST_SCAN_CLEAR_EN
      , .hist_wr_en(wr_en), .hist_wr_addr(wr_addr), .hist_wr_data(wr_data)
`endif
   );

   histogram_prefix_scanner #(.BIN_BITS(BB), .COUNT_WIDTH(NW), .INTENSITY_WIDTH(NW)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
      .hist_rd_en(rd_en_b), .hist_rd_addr(rd_addr_b), .hist_rd_data(rd_data_b),
      .total_pixels(tp_b), .total_intensity_sum(ts_b), .totals_valid(tv_b),
      .cumulative_count(cc_b), .cumulative_sum(cs_b),
      .out_valid(valid_b), .out_last(last_b), .out_ready(ready_b)
`ifdef HIST_SCAN_CLEAR_EN
      , .hist_wr_en(wr_en_b), .hist_wr_addr(wr_addr_b), .hist_wr_data(wr_data_b)
`endif
   );

   // Synchronous-read bin RAMs, bulk-loaded by the bench while the scanner is idle.
   logic [CW-1:0] mem_a[NB];
   logic [CW-1:0] ld_a[NB];
   logic          ld_a_req;
   logic [NW-1:0] mem_b[NB];
   logic [NW-1:0] ld_b[NB];
   logic          ld_b_req;

   always @(posedge clk) begin
      if (ld_a_req) for (int i = 0; i < NB; i++) mem_a[i] <= ld_a[i];
      if (rd_en) rd_data <= mem_a[rd_addr];
      if (ld_b_req) for (int i = 0; i < NB; i++) mem_b[i] <= ld_b[i];
      if (rd_en_b) rd_data_b <= mem_b[rd_addr_b];
`ifdef HIST_SCAN_CLEAR_EN
      if (wr_en) mem_a[wr_addr] <= wr_data;
      if (wr_en_b) mem_b[wr_addr_b] <= wr_data_b;
`endif
   end

   int checks = 0;
   int failures = 0;
   int cycle = 0;
   always @(posedge clk) cycle++;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   beat_t   exp_q[$];
   beat_b_t exp_qb[$];
   logic [CW-1:0] exp_tp;
   logic [IW-1:0] exp_ts;
   logic [NW-1:0] exp_tp_b, exp_ts_b;
   int  tv_cnt, done_cnt, beats_xfer, issued, xfers;
   int  xfer_cyc[$];
   bit  last_pend, in_scan;
   int  beats_b;

   // Monitor for the wide instance, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (last_pend) begin
            chk("done_after_last", 64'(done), 64'd1);
            last_pend = 1'b0;
         end
         if (done) begin
            done_cnt++;
            in_scan = 1'b0;
         end
         if (totals_valid) begin
            tv_cnt++;
            in_scan = 1'b1;
            chk("total_pixels", 64'(total_pixels), 64'(exp_tp));
            chk("total_isum", 64'(total_isum), 64'(exp_ts));
         end
         if (in_scan && rd_en) issued++;
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", 64'(out_valid), 64'd0);
            end else begin
               chk("cum_count", 64'(cum_cnt), 64'(exp_q[0].cnt));
               chk("cum_sum", 64'(cum_sum), 64'(exp_q[0].sum));
               chk("out_last", 64'(out_last), 64'(exp_q[0].last));
               if (out_ready) begin
                  if (exp_q[0].last) last_pend = 1'b1;
                  void'(exp_q.pop_front());
                  beats_xfer++;
                  xfers++;
                  xfer_cyc.push_back(cycle);
               end
            end
         end
         if (in_scan && rd_en) chk("fifo_overrun", 64'((issued - xfers) <= 2), 64'd1);
`ifdef HIST_SCAN_CLEAR_EN
         if (wr_en) wr_log.push_back(int'(wr_addr));
`endif
      end
   end

   // Monitor for the narrow (wrapping) instance.
   always @(negedge clk) begin
      if (rst_n) begin
         if (tv_b) begin
            chk("b_total_pixels", 64'(tp_b), 64'(exp_tp_b));
            chk("b_total_isum", 64'(ts_b), 64'(exp_ts_b));
         end
         if (valid_b && exp_qb.size() != 0) begin
            chk("b_cum_count", 64'(cc_b), 64'(exp_qb[0].cnt));
            chk("b_cum_sum", 64'(cs_b), 64'(exp_qb[0].sum));
            chk("b_out_last", 64'(last_b), 64'(exp_qb[0].last));
            if (ready_b) begin
               void'(exp_qb.pop_front());
               beats_b++;
            end
         end else if (valid_b) begin
            chk("b_unexpected_beat", 64'(valid_b), 64'd0);
         end
      end
   end

   task automatic load_a(input logic [CW-1:0] b0, b1, b2, b3);
      ld_a[0] = b0; ld_a[1] = b1; ld_a[2] = b2; ld_a[3] = b3;
      ld_a_req = 1'b1;
      @(posedge clk); #1;
      ld_a_req = 1'b0;
   endtask

   task automatic push_beat(input logic [CW-1:0] c, input logic [IW-1:0] s, input logic l);
      beat_t b;
      b.cnt = c; b.sum = s; b.last = l;
      exp_q.push_back(b);
   endtask

   task automatic expect_3052();
      exp_tp = 32'd10; exp_ts = 32'd16;
      push_beat(32'd3, 32'd0, 1'b0);
      push_beat(32'd3, 32'd0, 1'b0);
      push_beat(32'd8, 32'd10, 1'b0);
      push_beat(32'd10, 32'd16, 1'b1);
   endtask

   task automatic expect_zero();
      exp_tp = '0; exp_ts = '0;
      for (int i = 0; i < NB; i++) push_beat('0, '0, i == NB - 1);
   endtask

   task automatic new_test();
      tv_cnt = 0; done_cnt = 0; beats_xfer = 0; issued = 0; xfers = 0;
      xfer_cyc.delete();
   endtask

   task automatic do_start();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Runs until done, driving out_ready: mode 0 = held high, mode 1 = 3-cycle stall then toggle.
   task automatic run_until_done(input int mode, input int budget);
      bit seen = 1'b0;
      int stall = 0;
      for (int k = 0; k < budget; k++) begin
         @(posedge clk); #1;
         if (mode == 1 && beats_xfer >= 1) begin
            if (stall < 3) begin
               out_ready = 1'b0;
               stall++;
            end else begin
               out_ready = ~out_ready;
            end
         end else begin
            out_ready = 1'b1;
         end
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      out_ready = 1'b1;
      chk("scan_timeout", 64'(seen), 64'd1);
      @(posedge clk); #1;
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("idle_after_done", 64'(busy), 64'd0);
      chk("beats_remaining", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; out_ready = 1'b1;
      start_b = 1'b0; ready_b = 1'b1;
      ld_a_req = 1'b0; ld_b_req = 1'b0;
      exp_tp = '0; exp_ts = '0; exp_tp_b = '0; exp_ts_b = '0;
      beats_b = 0; last_pend = 1'b0; in_scan = 1'b0;
      new_test();
      #23;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rd_en", 64'(rd_en), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_total_pixels", 64'(total_pixels), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Bins {3,0,5,2}, ready held high.
      load_a(32'd3, 32'd0, 32'd5, 32'd2);
      new_test();
      expect_3052();
`ifdef HIST_SCAN_CLEAR_EN
      wr_log.delete();
`endif
      do_start();
      run_until_done(0, 60);
      chk("t1_totals_pulses", 64'(tv_cnt), 64'd1);
      chk("t1_done_pulses", 64'(done_cnt), 64'd1);
      chk("t1_beats", 64'(beats_xfer), 64'd4);
      if (xfer_cyc.size() == 4) chk("t1_throughput", 64'(xfer_cyc[3] - xfer_cyc[0]), 64'd3);
      chk("t1_totals_held", 64'(total_pixels), 64'd10);
      chk("t1_isum_held", 64'(total_isum), 64'd16);

`ifdef HIST_SCAN_CLEAR_EN
      chk("wr_count", 64'(wr_log.size()), 64'd4);
      for (int i = 0; i < wr_log.size() && i < NB; i++) chk("wr_addr_seq", 64'(wr_log[i]), 64'(i));
      new_test();
      expect_zero();
      do_start();
      run_until_done(0, 60);
      chk("clear_rescan_beats", 64'(beats_xfer), 64'd4);
`endif

      // Same bins with a stall then toggling ready.
      load_a(32'd3, 32'd0, 32'd5, 32'd2);
      new_test();
      expect_3052();
      do_start();
      run_until_done(1, 100);
      chk("t2_beats", 64'(beats_xfer), 64'd4);
      chk("t2_done_pulses", 64'(done_cnt), 64'd1);

      // All-zero histogram.
      load_a('0, '0, '0, '0);
      new_test();
      expect_zero();
      do_start();
      run_until_done(0, 60);
      chk("t3_beats", 64'(beats_xfer), 64'd4);

      // Narrow instance: sums wrap modulo 16.
      begin
         beat_b_t bb;
         bit seen_b = 1'b0;
         ld_b[0] = 4'd15; ld_b[1] = 4'd1; ld_b[2] = 4'd1; ld_b[3] = 4'd0;
         ld_b_req = 1'b1;
         @(posedge clk); #1;
         ld_b_req = 1'b0;
         exp_tp_b = 4'd1; exp_ts_b = 4'd3;
         bb = '{cnt: 4'd15, sum: 4'd0, last: 1'b0}; exp_qb.push_back(bb);
         bb = '{cnt: 4'd0,  sum: 4'd1, last: 1'b0}; exp_qb.push_back(bb);
         bb = '{cnt: 4'd1,  sum: 4'd3, last: 1'b0}; exp_qb.push_back(bb);
         bb = '{cnt: 4'd1,  sum: 4'd3, last: 1'b1}; exp_qb.push_back(bb);
         beats_b = 0;
         start_b = 1'b1;
         @(posedge clk); #1;
         start_b = 1'b0;
         for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (done_b) begin
               seen_b = 1'b1;
               break;
            end
         end
         chk("b_timeout", 64'(seen_b), 64'd1);
         chk("b_beats", 64'(beats_b), 64'd4);
         chk("b_busy_with_done", 64'(busy_b), 64'd1);
      end

      // Reset in SCAN after two beats, then ignored restart and a clean rescan.
      load_a(32'd3, 32'd0, 32'd5, 32'd2);
      new_test();
      expect_3052();
      do_start();
      begin
         bit got2 = 1'b0;
         int dc;
         for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (beats_xfer >= 2) begin
               got2 = 1'b1;
               break;
            end
         end
         chk("t5_two_beats", 64'(got2), 64'd1);
         rst_n = 1'b0;
         #1;
         chk("t5_busy", 64'(busy), 64'd0);
         chk("t5_done", 64'(done), 64'd0);
         chk("t5_rd_en", 64'(rd_en), 64'd0);
         chk("t5_rd_addr", 64'(rd_addr), 64'd0);
         chk("t5_total_pixels", 64'(total_pixels), 64'd0);
         chk("t5_total_isum", 64'(total_isum), 64'd0);
         chk("t5_totals_valid", 64'(totals_valid), 64'd0);
         chk("t5_cum_count", 64'(cum_cnt), 64'd0);
         chk("t5_cum_sum", 64'(cum_sum), 64'd0);
         chk("t5_out_valid", 64'(out_valid), 64'd0);
         chk("t5_out_last", 64'(out_last), 64'd0);
         exp_q.delete();
         last_pend = 1'b0;
         in_scan = 1'b0;
         dc = done_cnt;
         repeat (2) @(posedge clk);
         @(negedge clk);
         rst_n = 1'b1;
         repeat (4) @(posedge clk);
         #1;
         chk("t5_no_done", 64'(done_cnt), 64'(dc));
         chk("t5_idle", 64'(busy), 64'd0);
      end

      load_a(32'd3, 32'd0, 32'd5, 32'd2);
      new_test();
      expect_3052();
      do_start();
      repeat (3) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      run_until_done(0, 60);
      chk("t5_rescan_beats", 64'(beats_xfer), 64'd4);
      chk("t5_rescan_totals_pulses", 64'(tv_cnt), 64'd1);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/histogram_prefix_scanner.md
Name: histogram_prefix_scanner

Overview:
- Transmit side of the cumulative-sum stream consumed by the threshold prefix stage.
- Reads a completed intensity histogram from synchronous-read bin RAM in two passes:
  - Pass 1 computes total pixel count and total intensity sum.
  - Pass 2 emits per-bin cumulative count and cumulative intensity sum as a valid/ready stream, with last on the final bin.
- Sits between the histogram builder RAM and the prefix/threshold accumulator.

Parameters:
- BIN_BITS, 8, bin address width; NUM_BINS = 2**BIN_BITS.
- COUNT_WIDTH, 32, width of bin counts, cumulative_count and total_pixels.
- INTENSITY_WIDTH, 32, width of cumulative_sum and total_intensity_sum.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin scan; sampled only in IDLE
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse on scan completion
- hist_rd_en  out  1  bin RAM read strobe
- hist_rd_addr  out  BIN_BITS  bin RAM read address
- hist_rd_data  in  COUNT_WIDTH  bin count, valid exactly 1 cycle after hist_rd_en
- total_pixels  out  COUNT_WIDTH  sum of all bins; held until next start
- total_intensity_sum  out  INTENSITY_WIDTH  sum of bin_index*count; held until next start
- totals_valid  out  1  one-cycle pulse when totals are final
- cumulative_count  out  COUNT_WIDTH  running sum of counts, bins 0..k
- cumulative_sum  out  INTENSITY_WIDTH  running sum of i*count[i], i = 0..k
- out_valid  out  1  stream beat valid
- out_last  out  1  beat k = NUM_BINS-1
- out_ready  in  1  downstream accept

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0: busy, done, hist_rd_en, hist_rd_addr, totals, totals_valid, cumulative_*, out_valid, out_last. Internal FIFO emptied. Reset mid-scan aborts immediately; no done pulse.
- States: IDLE -> TOTAL -> ANNOUNCE -> SCAN -> DONE -> IDLE.
- IDLE:
  - start=1: clear accumulators and totals, go to TOTAL.
  - start outside IDLE is ignored.
- TOTAL:
  - hist_rd_en=1 every cycle, addresses 0..NUM_BINS-1 in consecutive cycles.
  - Each returned count is added to total_pixels; count*addr is added to total_intensity_sum, using the address registered alongside the read.
  - After the last data returns, go to ANNOUNCE.
- ANNOUNCE: totals_valid=1 for exactly one cycle, totals final; go to SCAN. The consumer captures totals on this pulse.
- SCAN:
  - Reads addresses 0..NUM_BINS-1 again. Each returned count is accumulated into a running cumulative pair and pushed into a 2-entry output FIFO whose head drives the stream outputs.
  - A read issues only when FIFO occupancy plus in-flight reads < 2. No loss under any out_ready pattern.
  - Throughput is 1 beat/cycle with out_ready held high; first out_valid 2 cycles after SCAN entry.
  - A beat transfers when out_valid && out_ready.
  - While out_valid=1 and out_ready=0: cumulative_count, cumulative_sum and out_last hold stable.
  - out_last=1 only on the beat for bin NUM_BINS-1.
  - Go to DONE when the last beat transfers.
- DONE: done=1 for one cycle; go to IDLE. Totals keep their values.
- Arithmetic: all sums are unsigned modulo 2**width, wrapping silently. The product count*index is computed at COUNT_WIDTH+BIN_BITS bits, then truncated to INTENSITY_WIDTH.
- Invariants:
  - Final cumulative_count == total_pixels.
  - Final cumulative_sum == total_intensity_sum.
  - hist_rd_en=0 in IDLE, ANNOUNCE and DONE.

Optional Feature:
- Macro: HIST_SCAN_CLEAR_EN.
- Defined:
  - Adds ports hist_wr_en (out, 1, reset 0), hist_wr_addr (out, BIN_BITS, reset 0) and hist_wr_data (out, COUNT_WIDTH, always 0).
  - In SCAN, the cycle each bin's read data returns, that bin is written with 0, clearing the RAM for the next frame.
  - The write for bin k never coincides with a read of bin k.
  - Not generated in TOTAL.
- Undefined: the ports do not exist and the RAM is never written.

Test Plan:
- BIN_BITS=2, bins {3,0,5,2}, out_ready=1 -> totals_valid with total_pixels=10, total_intensity_sum=16. Beats (3,0),(3,0),(8,10),(10,16); out_last only on 4th; done 1 cycle after 4th transfer.
- Same bins, out_ready low for 3 cycles after first beat, then toggling every cycle -> exactly 4 beats in order with identical values; outputs stable while stalled; hist_rd_en never overruns the 2-entry FIFO.
- All bins 0 -> totals 0/0; 4 beats all (0,0), last on 4th.
- COUNT_WIDTH=4, INTENSITY_WIDTH=4, bins {15,1,1,0} -> total_pixels=1 (17 mod 16), total_intensity_sum=3. Beats (15,0),(0,1),(1,3),(1,3).
- Reset asserted in SCAN after beat 2 -> all outputs 0 immediately, IDLE, no done. Second start issued while busy is ignored; a fresh start rescans correctly.
- With HIST_SCAN_CLEAR_EN: after the scan of {3,0,5,2}, a rescan yields totals 0/0; hist_wr_addr sequence 0,1,2,3.
